// File: rtl/roulette_spin_gen.sv
// Roulette wheel spin generator.
// A free-running 16-bit Galois LFSR picks the starting wheel position. The wheel
// then steps at a fixed rate, slows down step by step, and lands once the next
// step period would exceed MAX_PERIOD. The landed number is held on o_result
// until the next landing, and o_result_valid pulses for one cycle when it lands.
module roulette_spin_gen #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          MAX_NUM     = 31,
  parameter int          FAST_STEPS  = 8,
  parameter int          BASE_PERIOD = 4,
  parameter int          PERIOD_INC  = 4,
  parameter int          MAX_PERIOD  = 64
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  output logic [4:0] o_spin_value,
  output logic       o_busy,
  output logic       o_result_valid,
  output logic [4:0] o_result,
  output logic       o_is_even
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Period arithmetic is wide enough that period + PERIOD_INC never wraps.
  localparam int PW_RAW = $clog2(MAX_PERIOD + PERIOD_INC + 1);
  localparam int PW     = (PW_RAW > 8) ? PW_RAW : 8;

  localparam logic [4:0]    MAX_V   = 5'(MAX_NUM);
  localparam logic [4:0]    WRAP_V  = 5'(MAX_NUM + 1);
  localparam logic [PW-1:0] BASE_P  = PW'(BASE_PERIOD);
  localparam logic [PW-1:0] INC_P   = PW'(PERIOD_INC);
  localparam logic [PW-1:0] MAX_P   = PW'(MAX_PERIOD);
  localparam logic [5:0]    FAST_S  = 6'(FAST_STEPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SPIN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [15:0]   r_lfsr;
  logic [4:0]    r_spin;
  logic [PW-1:0] r_period;
  logic [PW-1:0] r_tick;
  logic [4:0]    r_steps;
  logic [4:0]    r_result;

  logic [15:0]   w_lfsr_next;
  logic [4:0]    w_start_pos;
  logic          w_step;
  logic [4:0]    w_spin_adv;
  logic [5:0]    w_steps_sum;
  logic [4:0]    w_steps_sat;
  logic [PW-1:0] w_p_next;
  logic          w_land;

  // Galois shift: the bit falling out of the bottom folds the tap mask back in.
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);

  // Start position is the low five LFSR bits folded into 0..MAX_NUM.
  assign w_start_pos = (r_lfsr[4:0] > MAX_V) ? (r_lfsr[4:0] - WRAP_V) : r_lfsr[4:0];

  // Step bookkeeping for the spinning wheel.
  assign w_step      = (r_state == S_SPIN) && (r_tick == (r_period - PW'(1)));
  assign w_spin_adv  = (r_spin == MAX_V) ? 5'd0 : (r_spin + 5'd1);
  assign w_steps_sum = {1'b0, r_steps} + 6'd1;
  assign w_steps_sat = (r_steps == 5'd31) ? 5'd31 : w_steps_sum[4:0];
  assign w_p_next    = (w_steps_sum >= FAST_S) ? (r_period + INC_P) : r_period;
  assign w_land      = w_step && (w_p_next > MAX_P);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE and is never queued.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_SPIN;
      S_SPIN:  if (w_land)  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    o_busy         = 1'b0;
    o_result_valid = 1'b0;
    case (r_state)
      S_SPIN:  o_busy = 1'b1;
      S_DONE:  o_result_valid = 1'b1;
      default: begin
        o_busy         = 1'b0;
        o_result_valid = 1'b0;
      end
    endcase
  end

  // Wheel datapath: LFSR free-runs; position, period, step and tick counters run the spin.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lfsr   <= SEED_EFF;
      r_spin   <= 5'd0;
      r_period <= BASE_P;
      r_tick   <= '0;
      r_steps  <= 5'd0;
      r_result <= 5'd0;
    end else begin
      r_lfsr <= w_lfsr_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_spin   <= w_start_pos;
            r_period <= BASE_P;
            r_tick   <= '0;
            r_steps  <= 5'd0;
          end
        end
        S_SPIN: begin
          if (w_step) begin
            r_tick  <= '0;
            r_spin  <= w_spin_adv;
            r_steps <= w_steps_sat;
            if (w_land) begin
              r_result <= w_spin_adv;
            end else begin
              r_period <= w_p_next;
            end
          end else begin
            r_tick <= r_tick + PW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_spin_value = r_spin;
  assign o_result     = r_result;
  assign o_is_even    = (r_result != 5'd0) && !r_result[0];

endmodule

// File: tb/tb_roulette_spin_gen.sv
// Self-checking bench for roulette_spin_gen.
// Instance 0 uses the default wheel; instance 1 uses a 0..17 wheel with a short
// deceleration profile so that many random spins fit in a short run.
module tb_roulette_spin_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst;
  logic [1:0]      start;
  logic [1:0]      busy;
  logic [1:0]      rv;
  logic [1:0]      ev;
  logic [1:0][4:0] sv;
  logic [1:0][4:0] res;

  logic [1:0][15:0] m_lfsr;
  logic [1:0][4:0]  exp_res;

  int n_checks = 0;
  int n_fail   = 0;

  // Wheel configuration of each instance as seen by the reference model.
  int c_maxn [2] = '{31, 17};
  int c_fast [2] = '{8, 3};
  int c_base [2] = '{4, 2};
  int c_inc  [2] = '{4, 3};
  int c_maxp [2] = '{64, 12};

  roulette_spin_gen u_dut0 (
    .i_clk          (clk),
    .i_reset        (rst[0]),
    .i_start        (start[0]),
    .o_spin_value   (sv[0]),
    .o_busy         (busy[0]),
    .o_result_valid (rv[0]),
    .o_result       (res[0]),
    .o_is_even      (ev[0])
  );

  roulette_spin_gen #(
    .LFSR_SEED   (16'h1D2B),
    .MAX_NUM     (17),
    .FAST_STEPS  (3),
    .BASE_PERIOD (2),
    .PERIOD_INC  (3),
    .MAX_PERIOD  (12)
  ) u_dut1 (
    .i_clk          (clk),
    .i_reset        (rst[1]),
    .i_start        (start[1]),
    .o_spin_value   (sv[1]),
    .o_busy         (busy[1]),
    .o_result_valid (rv[1]),
    .o_result       (res[1]),
    .o_is_even      (ev[1])
  );

  // Software Galois LFSR, tap mask 0xB400, shifting right.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    if (x[0]) return (x >> 1) ^ 16'hB400;
    return x >> 1;
  endfunction

  // Reference LFSR state for each instance, one advance per clock.
  always @(posedge clk) begin
    m_lfsr[0] <= rst[0] ? 16'hACE1 : lfsr_adv(m_lfsr[0]);
    m_lfsr[1] <= rst[1] ? 16'h1D2B : lfsr_adv(m_lfsr[1]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int even_of(input int r);
    return ((r != 0) && (r % 2 == 0)) ? 1 : 0;
  endfunction

  // Run one spin on instance u, starting from the current (IDLE) negedge.
  // mode 0: one-cycle start pulse; 1: start left high throughout (and on return);
  // mode 2: random start noise while spinning.
  // Returns at the negedge of the IDLE cycle that follows DONE.
  task automatic run_spin(input int u, input int mode);
    int wrap, per, stp, acc, pn, s, k, tot, land;
    int ends[$];
    int prev;
    wrap = c_maxn[u] + 1;
    per  = c_base[u];
    stp  = 0;
    acc  = 0;
    // Walk the deceleration schedule: cycle count after each completed step.
    forever begin
      acc += per;
      stp++;
      ends.push_back(acc);
      pn = (stp >= c_fast[u]) ? per + c_inc[u] : per;
      if (pn > c_maxp[u]) break;
      per = pn;
    end
    tot  = acc;
    s    = int'(m_lfsr[u][4:0]) % wrap;
    land = (s + stp) % wrap;
    prev = int'(exp_res[u]);
    k    = 0;
    start[u] = 1'b1;
    for (int j = 0; j <= tot + 1; j++) begin
      @(negedge clk);
      if (mode == 0) start[u] = 1'b0;
      else if (mode == 2) start[u] = (j <= tot) ? 1'($urandom_range(0, 1)) : 1'b0;
      while (k < stp && ends[k] <= j) k++;
      if (j < tot) begin
        chk($sformatf("u%0d busy c%0d", u, j), busy[u], 1);
        chk($sformatf("u%0d result_valid c%0d", u, j), rv[u], 0);
        chk($sformatf("u%0d spin_value c%0d", u, j), sv[u], (s + k) % wrap);
        chk($sformatf("u%0d result held c%0d", u, j), res[u], prev);
        chk($sformatf("u%0d is_even held c%0d", u, j), ev[u], even_of(prev));
      end else begin
        chk($sformatf("u%0d busy c%0d", u, j), busy[u], 0);
        chk($sformatf("u%0d result_valid c%0d", u, j), rv[u], (j == tot) ? 1 : 0);
        chk($sformatf("u%0d spin_value c%0d", u, j), sv[u], land);
        chk($sformatf("u%0d result c%0d", u, j), res[u], land);
        chk($sformatf("u%0d is_even c%0d", u, j), ev[u], even_of(land));
      end
    end
    exp_res[u] = 5'(land);
  endtask

  typedef struct packed {
    logic       r;
    logic       s;
    logic       b;
    logic       v;
    logic [4:0] spin;
    logic [4:0] result;
    logic       e;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int w;
    int gap;
    int mode;

    // Reset / idle vectors: reset wins over start, outputs stay zero afterwards.
    vecs[0] = '{r: 1'b1, s: 1'b0, b: 1'b0, v: 1'b0, spin: 5'd0, result: 5'd0, e: 1'b0};
    vecs[1] = '{r: 1'b1, s: 1'b1, b: 1'b0, v: 1'b0, spin: 5'd0, result: 5'd0, e: 1'b0};
    vecs[2] = '{r: 1'b0, s: 1'b0, b: 1'b0, v: 1'b0, spin: 5'd0, result: 5'd0, e: 1'b0};
    vecs[3] = '{r: 1'b0, s: 1'b0, b: 1'b0, v: 1'b0, spin: 5'd0, result: 5'd0, e: 1'b0};

    rst     = 2'b11;
    start   = 2'b00;
    exp_res = '0;

    for (int i = 0; i < 4; i++) begin
      rst[0]   = vecs[i].r;
      rst[1]   = vecs[i].r;
      start[0] = vecs[i].s;
      start[1] = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d busy", i), busy[0], vecs[i].b);
      chk($sformatf("vec%0d result_valid", i), rv[0], vecs[i].v);
      chk($sformatf("vec%0d spin_value", i), sv[0], vecs[i].spin);
      chk($sformatf("vec%0d result", i), res[0], vecs[i].result);
      chk($sformatf("vec%0d is_even", i), ev[0], vecs[i].e);
    end
    start[0] = 1'b0;

    // Default spin: 572 busy cycles, one result_valid, lands 23 past the start.
    run_spin(0, 0);

    // start held high: one landing per spin, next spin begins right after DONE.
    run_spin(0, 1);
    run_spin(0, 0);

    // Reset 100 cycles into a spin aborts it without a landing.
    start[0] = 1'b1;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      start[0] = 1'b0;
      chk($sformatf("abort busy c%0d", j), busy[0], 1);
      chk($sformatf("abort result_valid c%0d", j), rv[0], 0);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    exp_res[0] = 5'd0;
    chk("abort busy after reset", busy[0], 0);
    chk("abort result_valid after reset", rv[0], 0);
    chk("abort spin_value after reset", sv[0], 0);
    chk("abort result after reset", res[0], 0);
    chk("abort is_even after reset", ev[0], 0);
    @(negedge clk);
    chk("abort idle busy", busy[0], 0);
    chk("abort idle result_valid", rv[0], 0);

    // Start from position 30: wheel wraps 31 -> 0 -> 1 and lands on 21.
    w = 0;
    while (m_lfsr[0][4:0] != 5'd30 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("seek start position 30", (w < 5000) ? 1 : 0, 1);
    run_spin(0, 0);
    chk("pos30 landed result", res[0], 21);
    chk("pos30 landed is_even", ev[0], 0);

    // 200 random spins on the 0..17 wheel with random idle gaps and start noise.
    for (int n = 0; n < 200; n++) begin
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk($sformatf("u1 idle busy s%0d", n), busy[1], 0);
        chk($sformatf("u1 idle result_valid s%0d", n), rv[1], 0);
        chk($sformatf("u1 idle result s%0d", n), res[1], exp_res[1]);
        chk($sformatf("u1 idle is_even s%0d", n), ev[1], even_of(int'(exp_res[1])));
      end
      mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      run_spin(1, mode);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
